// File: rtl/jace_video_pkg.sv
// Jupiter Ace video generator: shared raster constants, default timing values,
// count types, the fetch-slot record handed from the counters to the fetch
// pipeline, and the screen-RAM index helper.
package jace_video_pkg;

  // Visible text area: 32 columns x 24 rows of 8x8 cells.
  localparam int COLS     = 32;
  localparam int ROWS     = 24;
  localparam int ACT_W    = COLS * 8;     // 256
  localparam int ACT_H    = ROWS * 8;     // 192
  localparam int SCR_SIZE = COLS * ROWS;  // 768

  // Default PAL-rate timing at a 6.5 MHz pixel clock.
  localparam int H_TOTAL_DEF     = 416;
  localparam int V_TOTAL_DEF     = 312;
  localparam int HSYNC_START_DEF = 320;
  localparam int HSYNC_LEN_DEF   = 32;
  localparam int VSYNC_START_DEF = 248;
  localparam int VSYNC_LEN_DEF   = 8;

  localparam int HC_W   = 9;
  localparam int VC_W   = 9;
  localparam int SCR_AW = 10;
  localparam int CHR_AW = 10;

  typedef logic [HC_W-1:0] hcount_t;
  typedef logic [VC_W-1:0] vcount_t;

  // Raster position of the upcoming cycle, reduced to what the fetch needs.
  typedef struct packed {
    logic [4:0] text_row;
    logic [4:0] col;
    logic [2:0] phase;
  } fetch_slot_t;

  // t*32 + c as a shift-add; 23*32+31 = 767 fits in 10 bits.
  function automatic logic [SCR_AW-1:0] scr_index(input logic [4:0] t,
                                                  input logic [4:0] c);
    return {t, 5'b00000} + {5'b00000, c};
  endfunction

endpackage

// File: rtl/jace_video_if.sv
// Video-RAM fetch and video output bundle of the Jupiter Ace video generator.
//   scr_addr/scr_data : screen RAM address (0..767) and 1-cycle-latency data
//   chr_addr/chr_data : char RAM address {code[6:0], row} and data, bit 7 leftmost
//   ri/gi/bi          : 3-bit colour, all ones = white, all zeros = black
//   hsync_n/vsync_n   : active-low syncs (vsync_n doubles as CPU INT)
//   vram_busy         : display fetch owns video RAM
// master = video generator, slave = RAM/scandoubler side.
interface jace_video_if;
  import jace_video_pkg::*;

  logic [SCR_AW-1:0] scr_addr;
  logic [7:0]        scr_data;
  logic [CHR_AW-1:0] chr_addr;
  logic [7:0]        chr_data;
  logic [2:0]        ri;
  logic [2:0]        gi;
  logic [2:0]        bi;
  logic              hsync_n;
  logic              vsync_n;
  logic              vram_busy;

  modport master (
    output scr_addr, chr_addr, ri, gi, bi, hsync_n, vsync_n, vram_busy,
    input  scr_data, chr_data
  );

  modport slave (
    input  scr_addr, chr_addr, ri, gi, bi, hsync_n, vsync_n, vram_busy,
    output scr_data, chr_data
  );

endinterface

// File: rtl/jace_video_counters.sv
// Raster counters for the Jupiter Ace video generator.
// hc counts 0..H_TOTAL-1 per line, vc counts 0..V_TOTAL-1 per frame. Sync and
// vram_busy are decoded from the next count and registered, so they change on
// the same edge as the counters.
// Ports:
//   clkvideo, rst  : pixel clock, asynchronous active-high reset
//   hc_phase       : hc[2:0] of the current cycle
//   glyph_row      : vc[2:0] of the current cycle
//   slot_nxt       : text row / column / phase of the next cycle
//   fetch_nxt      : next cycle lies inside the fetch region
//   hsync_n/vsync_n: registered active-low syncs
//   vram_busy      : registered fetch-region flag for the current cycle
module jace_video_counters
  import jace_video_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int HSYNC_START = HSYNC_START_DEF,
  parameter int HSYNC_LEN   = HSYNC_LEN_DEF,
  parameter int VSYNC_START = VSYNC_START_DEF,
  parameter int VSYNC_LEN   = VSYNC_LEN_DEF
) (
  input  logic        clkvideo,
  input  logic        rst,
  output logic [2:0]  hc_phase,
  output logic [2:0]  glyph_row,
  output fetch_slot_t slot_nxt,
  output logic        fetch_nxt,
  output logic        hsync_n,
  output logic        vsync_n,
  output logic        vram_busy
);

  hcount_t hc;
  hcount_t hc_nxt;
  vcount_t vc;
  vcount_t vc_nxt;
  logic    running;

  // The first edge after reset only arms the counters, so that edge lands on
  // hc=0/vc=0 with the line-0 fetch outputs already presented.
  always_comb begin
    hc_nxt = hc;
    vc_nxt = vc;
    if (running) begin
      if (hc == hcount_t'(H_TOTAL - 1)) begin
        hc_nxt = '0;
        if (vc == vcount_t'(V_TOTAL - 1)) vc_nxt = '0;
        else                              vc_nxt = vc + vcount_t'(1);
      end else begin
        hc_nxt = hc + hcount_t'(1);
      end
    end
  end

  assign fetch_nxt = (int'(vc_nxt) < ACT_H) && (int'(hc_nxt) < ACT_W);
  assign slot_nxt  = '{text_row: vc_nxt[7:3], col: hc_nxt[7:3], phase: hc_nxt[2:0]};
  assign hc_phase  = hc[2:0];
  assign glyph_row = vc[2:0];

  always_ff @(posedge clkvideo or posedge rst) begin
    if (rst) begin
      hc        <= '0;
      vc        <= '0;
      running   <= 1'b0;
      hsync_n   <= 1'b1;
      vsync_n   <= 1'b1;
      vram_busy <= 1'b0;
    end else begin
      hc        <= hc_nxt;
      vc        <= vc_nxt;
      running   <= 1'b1;
      hsync_n   <= !((int'(hc_nxt) >= HSYNC_START) &&
                     (int'(hc_nxt) <  HSYNC_START + HSYNC_LEN));
      vsync_n   <= !((int'(vc_nxt) >= VSYNC_START) &&
                     (int'(vc_nxt) <  VSYNC_START + VSYNC_LEN));
      vram_busy <= fetch_nxt;
    end
  end

endmodule

// File: rtl/jace_video_gen.sv
// Jupiter Ace video generator top.
// Fetches a character code per 8-pixel column, then the glyph row for it, and
// shifts the (optionally inverted) glyph out MSB first as monochrome pixels.
// Column c's first pixel appears at hc=8c+9.
// Ports:
//   clkvideo : pixel clock
//   rst      : asynchronous active-high reset
//   vif      : jace_video_if.master (RAM fetch, RGB, syncs, vram_busy)
module jace_video_gen
  import jace_video_pkg::*;
#(
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int HSYNC_START = HSYNC_START_DEF,
  parameter int HSYNC_LEN   = HSYNC_LEN_DEF,
  parameter int VSYNC_START = VSYNC_START_DEF,
  parameter int VSYNC_LEN   = VSYNC_LEN_DEF
) (
  input logic          clkvideo,
  input logic          rst,
  jace_video_if.master vif
);

  logic [2:0]  hc_phase;
  logic [2:0]  glyph_row;
  fetch_slot_t slot_nxt;
  logic        fetch_nxt;
  logic        in_fetch;
  logic        hsync_n;
  logic        vsync_n;

  jace_video_counters #(
    .H_TOTAL    (H_TOTAL),
    .V_TOTAL    (V_TOTAL),
    .HSYNC_START(HSYNC_START),
    .HSYNC_LEN  (HSYNC_LEN),
    .VSYNC_START(VSYNC_START),
    .VSYNC_LEN  (VSYNC_LEN)
  ) u_counters (
    .clkvideo (clkvideo),
    .rst      (rst),
    .hc_phase (hc_phase),
    .glyph_row(glyph_row),
    .slot_nxt (slot_nxt),
    .fetch_nxt(fetch_nxt),
    .hsync_n  (hsync_n),
    .vsync_n  (vsync_n),
    .vram_busy(in_fetch)
  );

  logic [SCR_AW-1:0] scr_addr_p0;
  logic [CHR_AW-1:0] chr_addr_p1;
  logic              inv_p1;
  logic              inv_p2;
  logic [7:0]        glyph_p2;
  logic [7:0]        shift_p3;
  logic              pix_p4;
  logic              addr_slot;
  logic              code_slot;
  logic              glyph_slot;
  logic              load_slot;

  always_comb begin
    addr_slot  = fetch_nxt && (slot_nxt.phase == 3'd0);
    code_slot  = in_fetch && (hc_phase == 3'd1);
    glyph_slot = in_fetch && (hc_phase == 3'd2);
    load_slot  = (hc_phase == 3'd7);
  end

  // p0: screen address, presented on the edge where hc becomes 8c
  always_ff @(posedge clkvideo or posedge rst) begin
    if (rst)            scr_addr_p0 <= '0;
    else if (addr_slot) scr_addr_p0 <= scr_index(slot_nxt.text_row, slot_nxt.col);
  end

  // p1: code arrives at hc=8c+1; the char address is driven straight from it
  // in that cycle and held in chr_addr_p1 afterwards.
  always_ff @(posedge clkvideo or posedge rst) begin
    if (rst) begin
      chr_addr_p1 <= '0;
      inv_p1      <= 1'b0;
    end else if (code_slot) begin
      chr_addr_p1 <= {vif.scr_data[6:0], glyph_row};
      inv_p1      <= vif.scr_data[7];
    end
  end

  // p2: glyph row arrives at hc=8c+2
  always_ff @(posedge clkvideo or posedge rst) begin
    if (rst) begin
      glyph_p2 <= '0;
      inv_p2   <= 1'b0;
    end else if (glyph_slot) begin
      glyph_p2 <= vif.chr_data;
      inv_p2   <= inv_p1;
    end
  end

  // p3: shifter; loads at hc=8c+7, black when the column is outside the fetch
  // region so the border and blanking drain to zero.
  always_ff @(posedge clkvideo or posedge rst) begin
    if (rst)            shift_p3 <= '0;
    else if (load_slot) shift_p3 <= in_fetch ? (glyph_p2 ^ {8{inv_p2}}) : 8'h00;
    else                shift_p3 <= {shift_p3[6:0], 1'b0};
  end

  // p4: registered pixel
  always_ff @(posedge clkvideo or posedge rst) begin
    if (rst) pix_p4 <= 1'b0;
    else     pix_p4 <= shift_p3[7];
  end

  assign vif.scr_addr  = scr_addr_p0;
  assign vif.chr_addr  = code_slot ? {vif.scr_data[6:0], glyph_row} : chr_addr_p1;
  assign vif.ri        = {3{pix_p4}};
  assign vif.gi        = {3{pix_p4}};
  assign vif.bi        = {3{pix_p4}};
  assign vif.hsync_n   = hsync_n;
  assign vif.vsync_n   = vsync_n;
  assign vif.vram_busy = in_fetch;

endmodule

// File: tb/tb_jace_video_gen.sv
// Bench for jace_video_gen with a shortened raster so a whole frame fits.
// Reference: pixel/sync/address values computed per raster position from the
// cell-grid rules against the bench's own RAM images.
module tb_jace_video_gen;
  import jace_video_pkg::*;

  localparam int H  = 280;
  localparam int V  = 196;
  localparam int HS = 270;
  localparam int HL = 8;
  localparam int VS = 193;
  localparam int VL = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  jace_video_if vif();

  jace_video_gen #(
    .H_TOTAL(H), .V_TOTAL(V), .HSYNC_START(HS), .HSYNC_LEN(HL),
    .VSYNC_START(VS), .VSYNC_LEN(VL)
  ) dut (
    .clkvideo(clk),
    .rst     (rst),
    .vif     (vif)
  );

  logic [7:0] scr_mem [0:1023];
  logic [7:0] chr_mem [0:1023];

  // Synchronous RAMs, one-cycle read latency.
  always @(posedge clk) begin
    vif.scr_data <= scr_mem[vif.scr_addr];
    vif.chr_data <= chr_mem[vif.chr_addr];
  end

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  int         k;
  logic [9:0] exp_scr;
  logic [9:0] exp_chr;
  int         hist [0:1023];
  int         hs_last;
  logic       hs_prev;
  int         vs_low;
  int         busy_cnt;
  logic [7:0] a5_pat;

  function automatic logic model_pix(input int vc, input int hc);
    int         c;
    int         b;
    logic [7:0] code;
    logic [7:0] g;
    logic [9:0] ca;
    if (vc >= 192 || hc < 9 || hc > 264) return 1'b0;
    c    = (hc - 9) / 8;
    b    = (hc - 9) % 8;
    code = scr_mem[(vc / 8) * 32 + c];
    ca   = {code[6:0], 3'(vc % 8)};
    g    = chr_mem[ca];
    if (code[7]) g = ~g;
    return g[7 - b];
  endfunction

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rgb"},  32'({vif.ri, vif.gi, vif.bi}), 32'd0);
    chk({tag, "_hs"},   32'(vif.hsync_n), 32'd1);
    chk({tag, "_vs"},   32'(vif.vsync_n), 32'd1);
    chk({tag, "_busy"}, 32'(vif.vram_busy), 32'd0);
    chk({tag, "_scr"},  32'(vif.scr_addr), 32'd0);
    chk({tag, "_chr"},  32'(vif.chr_addr), 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset_vals("pre");
    k        = 0;
    exp_scr  = '0;
    exp_chr  = '0;
    hs_prev  = 1'b1;
    hs_last  = -1;
    vs_low   = 0;
    busy_cnt = 0;
  endtask

  task automatic step(input bit phase_b);
    int         hc;
    int         vc;
    logic       p;
    logic [7:0] code;
    logic       fetch;
    @(negedge clk);
    hc    = k % H;
    vc    = (k / H) % V;
    fetch = (vc < 192) && (hc < 256);
    if (fetch && hc % 8 == 0) exp_scr = 10'((vc / 8) * 32 + hc / 8);
    if (fetch && hc % 8 == 1) begin
      code    = scr_mem[(vc / 8) * 32 + hc / 8];
      exp_chr = {code[6:0], 3'(vc % 8)};
    end
    p = model_pix(vc, hc);
    chk($sformatf("rgb@%0d/%0d", vc, hc), 32'({vif.ri, vif.gi, vif.bi}), 32'({9{p}}));
    chk($sformatf("hs@%0d/%0d", vc, hc), 32'(vif.hsync_n), 32'(!(hc >= HS && hc < HS + HL)));
    chk($sformatf("vs@%0d/%0d", vc, hc), 32'(vif.vsync_n), 32'(!(vc >= VS && vc < VS + VL)));
    chk($sformatf("busy@%0d/%0d", vc, hc), 32'(vif.vram_busy), 32'(fetch));
    chk($sformatf("scr@%0d/%0d", vc, hc), 32'(vif.scr_addr), 32'(exp_scr));
    chk($sformatf("chr@%0d/%0d", vc, hc), 32'(vif.chr_addr), 32'(exp_chr));
    if (hs_prev && !vif.hsync_n) begin
      chk("hs_fall_hc", 32'(hc), 32'(HS));
      if (hs_last >= 0) chk("hs_period", 32'(k - hs_last), 32'(H));
      hs_last = k;
    end
    hs_prev = vif.hsync_n;
    if (!phase_b && vc == 0 && hc >= 9 && hc <= 264)
      chk("a5_pat", 32'(vif.ri[0]), 32'(a5_pat[7 - (hc - 9) % 8]));
    if (phase_b) begin
      if (vc >= 16 && vc <= 23 && hc == 40) chk("cell_scr", 32'(vif.scr_addr), 32'd69);
      if (vc >= 16 && vc <= 23 && hc == 41) chk("cell_chr", 32'(vif.chr_addr), 32'(8 + vc % 8));
      if (k < H * V) begin
        if (!vif.vsync_n) vs_low++;
        if (vif.vram_busy) busy_cnt++;
        if (fetch && hc % 8 == 0) hist[vif.scr_addr]++;
      end
    end
    k++;
  endtask

  initial begin
    a5_pat = 8'hA5;
    for (int i = 0; i < 1024; i++) begin
      scr_mem[i] = 8'h00;
      chr_mem[i] = 8'hA5;
      hist[i]    = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("rst");

    // Phase A: blank screen, every glyph row 0xA5; reset mid-line at vc=1 hc=123.
    release_reset();
    for (int i = 0; i < H + 124; i++) step(1'b0);
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals("async_a");
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("hold_a");

    // Phase B: random RAM contents with an inverse cell at (t=2, c=5).
    for (int i = 0; i < 1024; i++) begin
      scr_mem[i] = 8'($urandom);
      chr_mem[i] = 8'($urandom);
    end
    scr_mem[69] = 8'h81;
    release_reset();
    for (int i = 0; i < H * V + 2 * H + HS + 2; i++) step(1'b1);
    #1;
    rst = 1'b1;
    #1;
    check_reset_vals("async_b");

    chk("vs_low_cnt", 32'(vs_low), 32'(VL * H));
    chk("busy_cnt", 32'(busy_cnt), 32'(192 * 256));
    for (int a = 0; a < 1024; a++)
      chk($sformatf("hist%0d", a), 32'(hist[a]), (a < SCR_SIZE) ? 32'd8 : 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
